// File: rtl/gesture_uart_tx_fifo.sv
// Gesture UART transmitter: FIFO-buffered 8N1-style serialiser with configurable baud, width and stop bits.
// Optional parity bit after the data bits when UART_TX_PARITY_EN is defined (PARITY_ODD selects odd/even).
module gesture_uart_tx_fifo #(
   parameter int CLK_HZ     = 50000000,
   parameter int BAUD       = 9600,
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 8,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic                          Clk_i,
   input  logic                          Reset_i,
   input  logic                          Data_Available_i,
   input  logic [DATA_W-1:0]             Data_i,
   input  logic                          Ovf_Clr_i,
   output logic                          Tx_o,
   output logic                          Busy_o,
   output logic                          Full_o,
   output logic                          Overflow_o,
   output logic [$clog2(FIFO_DEPTH):0]   Fifo_Count_o
);

   localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam int PTR_W        = $clog2(FIFO_DEPTH);
   localparam int STOP_CLKS    = STOP_BITS * CLKS_PER_BIT;
   localparam int BAUD_W       = $clog2(STOP_CLKS);
   localparam int IDX_W        = $clog2(DATA_W);

   localparam logic [BAUD_W-1:0] BIT_RELOAD  = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] STOP_RELOAD = BAUD_W'(STOP_CLKS - 1);
   localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(DATA_W - 1);
   localparam logic [PTR_W:0]    DEPTH_CNT   = (PTR_W + 1)'(FIFO_DEPTH);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd3;
`endif
   localparam logic [2:0] S_STOP   = 3'd4;

   if (CLKS_PER_BIT < 2 || DATA_W < 5 || DATA_W > 9 || FIFO_DEPTH < 2 ||
       (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || STOP_BITS < 1 || STOP_BITS > 2 ||
       PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
      $error("gesture_uart_tx_fifo: illegal parameter combination");
   end

   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]    count_q, count_d;
   logic              full_q, full_d;
   logic              ovf_q, ovf_d;
   logic              busy_q, busy_d;
   logic              tx_q, tx_d;
   logic [2:0]        state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0] shift_q, shift_d;
`ifdef UART_TX_PARITY_EN
   logic              par_q, par_d;
`endif
   logic              wr_en, drop, pop;

   // Fullness is judged on the registered count, so a write while full is dropped even if a pop coincides.
   assign wr_en = Data_Available_i & ~full_q;
   assign drop  = Data_Available_i & full_q;
   assign pop   = (state_q == S_IDLE) && (count_q != '0);

   // NOTE: storage has no reset; only pointers and count define validity, so stale words are never read.
   always_ff @(posedge Clk_i) begin
      if (wr_en) mem_q[wr_ptr_q] <= Data_i;
   end

   always_comb begin
      // NOTE: every comb output gets a default first so no path can infer a latch.
      count_d = count_q;
      case ({wr_en, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      full_d = (count_d == DEPTH_CNT);
      ovf_d  = drop ? 1'b1 : (Ovf_Clr_i ? 1'b0 : ovf_q);
   end

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      idx_d   = idx_q;
      shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (pop) begin
               state_d = S_START;
               baud_d  = BIT_RELOAD;
               shift_d = mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
               par_d   = (^mem_q[rd_ptr_q]) ^ (PARITY_ODD != 0);
`endif
            end
         end
         S_START: begin
            if (baud_q == '0) begin
               state_d = S_DATA;
               baud_d  = BIT_RELOAD;
               idx_d   = '0;
            end else begin
               baud_d = baud_q - 1'b1;
            end
         end
         S_DATA: begin
            if (baud_q != '0) begin
               baud_d = baud_q - 1'b1;
            end else if (idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
               state_d = S_PARITY;
               baud_d  = BIT_RELOAD;
`else
               state_d = S_STOP;
               baud_d  = STOP_RELOAD;
`endif
            end else begin
               idx_d   = idx_q + 1'b1;
               shift_d = shift_q >> 1;
               baud_d  = BIT_RELOAD;
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (baud_q == '0) begin
               state_d = S_STOP;
               baud_d  = STOP_RELOAD;
            end else begin
               baud_d = baud_q - 1'b1;
            end
         end
`endif
         S_STOP: begin
            if (baud_q == '0) state_d = S_IDLE;
            else              baud_d  = baud_q - 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Line level follows the current state, so Tx_o trails the FSM by one cycle and never sees an input directly.
   always_comb begin
      case (state_q)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
         S_PARITY: tx_d = par_q;
`endif
         default: tx_d = 1'b1;
      endcase
      busy_d = (state_d != S_IDLE) || (count_d != '0);
   end

   // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge Clk_i or posedge Reset_i) begin
      if (Reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         ovf_q    <= 1'b0;
         busy_q   <= 1'b0;
         tx_q     <= 1'b1;
         state_q  <= S_IDLE;
         baud_q   <= '0;
         idx_q    <= '0;
         shift_q  <= '0;
`ifdef UART_TX_PARITY_EN
         par_q    <= 1'b0;
`endif
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
         full_q  <= full_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         tx_q    <= tx_d;
         state_q <= state_d;
         baud_q  <= baud_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   assign Tx_o         = tx_q;
   assign Busy_o       = busy_q;
   assign Full_o       = full_q;
   assign Overflow_o   = ovf_q;
   assign Fifo_Count_o = count_q;

endmodule

// File: tb/tb_gesture_uart_tx_fifo.sv
// Directed bench for gesture_uart_tx_fifo: two instances (depth 4 / 1 stop, depth 8 / 2 stops), 10 clocks per bit.
// Parity expectations follow UART_TX_PARITY_EN when the bundle is built with it.
module tb_gesture_uart_tx_fifo;

   localparam int CPB = 10;

   logic       clk = 1'b0;
   logic       rst, da1, da2, clr, sel;
   logic [7:0] din;
   logic       tx1, busy1, full1, ovf1;
   logic [2:0] cnt1;
   logic       tx2, busy2, full2, ovf2;
   logic [3:0] cnt2;
   logic       tx_mon;
   int         passed = 0;
   int         total  = 0;

   always #5 clk = ~clk;
   assign tx_mon = sel ? tx2 : tx1;

   gesture_uart_tx_fifo #(
      .CLK_HZ(1000000), .BAUD(100000), .DATA_W(8), .FIFO_DEPTH(4), .STOP_BITS(1), .PARITY_ODD(0)
   ) u_dut (
      .Clk_i(clk), .Reset_i(rst), .Data_Available_i(da1), .Data_i(din), .Ovf_Clr_i(clr),
      .Tx_o(tx1), .Busy_o(busy1), .Full_o(full1), .Overflow_o(ovf1), .Fifo_Count_o(cnt1)
   );

   gesture_uart_tx_fifo #(
      .CLK_HZ(1000000), .BAUD(100000), .DATA_W(8), .FIFO_DEPTH(8), .STOP_BITS(2), .PARITY_ODD(1)
   ) u_dut2 (
      .Clk_i(clk), .Reset_i(rst), .Data_Available_i(da2), .Data_i(din), .Ovf_Clr_i(clr),
      .Tx_o(tx2), .Busy_o(busy2), .Full_o(full2), .Overflow_o(ovf2), .Fifo_Count_o(cnt2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   // Bounded search for the first start-bit cycle on the monitored line.
   task automatic wait_start(input string tag, input int budget);
      int n = 0;
      while (tx_mon !== 1'b0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_start_seen"}, {31'd0, tx_mon}, 32'd0);
   endtask

   // Entered on the first start-bit cycle; every cycle of every bit must carry the expected level.
   task automatic expect_frame(input string tag, input logic [7:0] w, input int nstop, input bit odd);
      logic bits [16];
      int   nb;
      int   good;
      nb = 0;
      bits[nb] = 1'b0; nb++;
      for (int i = 0; i < 8; i++) begin
         bits[nb] = w[i]; nb++;
      end
`ifdef UART_TX_PARITY_EN
      bits[nb] = (^w) ^ odd; nb++;
`else
      if (odd) good = 0;
`endif
      for (int s = 0; s < nstop; s++) begin
         bits[nb] = 1'b1; nb++;
      end
      for (int b = 0; b < nb; b++) begin
         good = 0;
         repeat (CPB) begin
            if (tx_mon === bits[b]) good++;
            @(negedge clk);
         end
         check($sformatf("%s_bit%0d", tag, b), good, CPB);
      end
   endtask

   task automatic idle_gap(input string tag);
      check({tag, "_idle_gap"}, {31'd0, tx_mon}, 32'd1);
      @(negedge clk);
   endtask

   task automatic quiet_line(input string tag, input int cycles);
      int lows = 0;
      repeat (cycles) begin
         if (tx_mon !== 1'b1) lows++;
         @(negedge clk);
      end
      check({tag, "_quiet"}, lows, 0);
   endtask

   initial begin
      logic [7:0] w3 [6];
      int         peak;
      w3 = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65};
      rst = 1'b1; da1 = 1'b0; da2 = 1'b0; din = 8'h00; clr = 1'b0; sel = 1'b0;

      // Reset state
      #12;
      check("rst_tx", {31'd0, tx1}, 32'd1);
      check("rst_busy", {31'd0, busy1}, 32'd0);
      check("rst_full", {31'd0, full1}, 32'd0);
      check("rst_ovf", {31'd0, ovf1}, 32'd0);
      check("rst_cnt", {29'd0, cnt1}, 32'd0);
      check("rst_tx2", {31'd0, tx2}, 32'd1);
      @(negedge clk); rst = 1'b0;

      // Data_i toggling without a strobe must not enqueue anything
      repeat (4) begin
         din = din + 8'h5A;
         @(negedge clk);
      end
      check("ignore_cnt", {29'd0, cnt1}, 32'd0);
      check("ignore_busy", {31'd0, busy1}, 32'd0);

      // Test 1: single 0xA5, start bit appears two edges after the write
      da1 = 1'b1; din = 8'hA5;
      @(negedge clk); da1 = 1'b0;
      check("t1_cnt_after_wr", {29'd0, cnt1}, 32'd1);
      check("t1_busy_after_wr", {31'd0, busy1}, 32'd1);
      check("t1_tx_edge1", {31'd0, tx1}, 32'd1);
      @(negedge clk);
      check("t1_tx_edge2", {31'd0, tx1}, 32'd1);
      check("t1_cnt_popped", {29'd0, cnt1}, 32'd0);
      @(negedge clk);
      check("t1_tx_latency", {31'd0, tx1}, 32'd0);
      expect_frame("t1", 8'hA5, 1, 1'b0);
      check("t1_busy_end", {31'd0, busy1}, 32'd0);
      quiet_line("t1", 5);

      // Test 2: three back-to-back writes; pop coincides with the second write
      peak = 0;
      da1 = 1'b1; din = 8'h01;
      @(negedge clk); if (int'(cnt1) > peak) peak = int'(cnt1); din = 8'h02;
      @(negedge clk); if (int'(cnt1) > peak) peak = int'(cnt1); din = 8'h03;
      check("t2_cnt_wr_and_pop", {29'd0, cnt1}, 32'd1);
      @(negedge clk); if (int'(cnt1) > peak) peak = int'(cnt1); da1 = 1'b0;
      check("t2_peak", peak, 2);
      check("t2_tx_latency", {31'd0, tx1}, 32'd0);
      expect_frame("t2a", 8'h01, 1, 1'b0);
      idle_gap("t2a");
      expect_frame("t2b", 8'h02, 1, 1'b0);
      idle_gap("t2b");
      expect_frame("t2c", 8'h03, 1, 1'b0);
      check("t2_busy_end", {31'd0, busy1}, 32'd0);
      quiet_line("t2", 5);

      // Test 3: overflow on a depth-4 FIFO while the first frame is on the wire
      da1 = 1'b1; din = w3[0];
      @(negedge clk); da1 = 1'b0;
      wait_start("t3", 5);
      fork
         expect_frame("t3a", w3[0], 1, 1'b0);
         begin
            for (int i = 1; i < 6; i++) begin
               da1 = 1'b1; din = w3[i]; clr = (i == 5);
               @(negedge clk);
            end
            da1 = 1'b0; clr = 1'b0;
            check("t3_cnt_full", {29'd0, cnt1}, 32'd4);
            check("t3_full", {31'd0, full1}, 32'd1);
            check("t3_ovf_set_wins", {31'd0, ovf1}, 32'd1);
            repeat (5) @(negedge clk);
            check("t3_ovf_sticky", {31'd0, ovf1}, 32'd1);
            clr = 1'b1;
            @(negedge clk); clr = 1'b0;
            check("t3_ovf_cleared", {31'd0, ovf1}, 32'd0);
            check("t3_cnt_after_clr", {29'd0, cnt1}, 32'd4);
         end
      join
      check("t3_cnt_after_pop", {29'd0, cnt1}, 32'd3);
      check("t3_full_after_pop", {31'd0, full1}, 32'd0);
      for (int i = 1; i < 5; i++) begin
         idle_gap($sformatf("t3_%0d", i));
         expect_frame($sformatf("t3_w%0d", i), w3[i], 1, 1'b0);
      end
      quiet_line("t3_no_sixth", 30);
      check("t3_busy_end", {31'd0, busy1}, 32'd0);

      // Test 4: 0x07 (parity 1 even / 0 odd when parity is built in)
      da1 = 1'b1; din = 8'h07;
      @(negedge clk); da1 = 1'b0;
      wait_start("t4e", 5);
      expect_frame("t4e", 8'h07, 1, 1'b0);
      check("t4e_busy_end", {31'd0, busy1}, 32'd0);
      sel = 1'b1;
      da2 = 1'b1;
      @(negedge clk); da2 = 1'b0;
      wait_start("t4o", 5);
      expect_frame("t4o", 8'h07, 2, 1'b1);
      quiet_line("t4o", 3);

      // Test 5: two stop bits, 0x00 then 0xFF
      da2 = 1'b1; din = 8'h00;
      @(negedge clk); din = 8'hFF;
      @(negedge clk); da2 = 1'b0;
      check("t5_tx_edge2", {31'd0, tx2}, 32'd1);
      @(negedge clk);
      check("t5_tx_latency", {31'd0, tx2}, 32'd0);
      expect_frame("t5a", 8'h00, 2, 1'b1);
      idle_gap("t5a");
      expect_frame("t5b", 8'hFF, 2, 1'b1);
      check("t5_busy_end", {31'd0, busy2}, 32'd0);
      sel = 1'b0;

      // Test 6: asynchronous reset in the middle of DATA with two words queued
      da1 = 1'b1; din = 8'h11;
      @(negedge clk); din = 8'h22;
      @(negedge clk); din = 8'h33;
      @(negedge clk); da1 = 1'b0;
      repeat (35) @(negedge clk);
      check("t6_cnt_queued", {29'd0, cnt1}, 32'd2);
      #2 rst = 1'b1;
      #1;
      check("t6_tx_now", {31'd0, tx1}, 32'd1);
      check("t6_cnt_now", {29'd0, cnt1}, 32'd0);
      check("t6_busy_now", {31'd0, busy1}, 32'd0);
      @(negedge clk); rst = 1'b0;
      quiet_line("t6_after_rst", 250);
      check("t6_busy_idle", {31'd0, busy1}, 32'd0);
      da1 = 1'b1; din = 8'h3C;
      @(negedge clk); da1 = 1'b0;
      wait_start("t6", 5);
      expect_frame("t6_new", 8'h3C, 1, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
